cpu_paddle_ctrl: RTL and testbench
==================================

Name: cpu_paddle_ctrl

Overview:
- Computer opponent for the right-hand paddle of the Pong game.
- Reads the ball position published by the game core, once per video frame, and drives up/down move requests to the paddle logic.
- Models a human-like reaction delay and a dead zone so the CPU can be beaten.
- Sits beside the game core in tt_um_PongGame. It is the consumer of current_ball_x_pos/current_ball_y_pos and the producer of the CPU side's paddle commands.

Parameters:
- POS_W, 10, width of all position buses
- SCREEN_H, 480, visible lines; home target = SCREEN_H/2
- PADDLE_H, 64, paddle height in pixels; paddle centre = paddle_y + PADDLE_H/2
- DEAD_ZONE, 4, no move while |centre - target| <= DEAD_ZONE
- REACT_FRAMES, 2, frame ticks between approach detection and tracking (0..15)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  CPU player active; low forces HOME with no moves
- frame_tick  in  1  one-cycle pulse per frame; all decisions are taken only on this cycle
- ball_x  in  POS_W  current ball x (0 = left edge, CPU on right)
- ball_y  in  POS_W  current ball y
- paddle_y  in  POS_W  top of CPU paddle
- paddle_up  out  1  move-up request, held for one full frame
- paddle_down  out  1  move-down request, held for one full frame
- state  out  2  debug: 0 HOME, 1 WAIT, 2 TRACK

Behaviour:
- Reset (async, rst_n low) values:
  - paddle_up=0, paddle_down=0, state=HOME
  - prev_x=0, prev_valid=0, react counter=0
- Registers change only on cycles where frame_tick=1; they hold on all other cycles.
- On each tick:
  - approaching = prev_valid & (ball_x > prev_x); equal x counts as not approaching.
  - prev_x <= ball_x; prev_valid <= 1.
- States:
  - HOME: approaching & REACT_FRAMES=0 -> TRACK. Otherwise approaching -> WAIT, counter loaded with REACT_FRAMES. Otherwise stay.
  - WAIT: not approaching -> HOME. Otherwise counter <= 1 -> TRACK. Otherwise counter decrements and the block stays in WAIT. TRACK is therefore entered exactly REACT_FRAMES ticks after the detecting tick.
  - TRACK: not approaching -> HOME. Otherwise stay.
  - enable=0 at a tick -> HOME, both outputs 0, counter cleared. prev_x is still updated.
- Outputs are registered on the same tick, from the state being entered:
  - target = ball_y in TRACK, SCREEN_H/2 in HOME or WAIT.
  - centre = paddle_y + PADDLE_H/2, computed at POS_W+1 bits so it cannot overflow.
  - centre + DEAD_ZONE < target -> paddle_down=1.
  - centre > target + DEAD_ZONE -> paddle_up=1.
  - Otherwise both 0.
  - paddle_up and paddle_down are never both 1.
- Latency: one clock from the frame_tick cycle to the output change.
- A new tick arriving the cycle immediately after a previous tick is processed normally; there is no minimum spacing.
- Reset mid-frame clears everything immediately. The first tick after reset cannot detect an approach.

Test Plan:
- Reset, then paddle_y=100 (centre 132), ball_x=100, tick -> state HOME, paddle_down=1 (132<236), paddle_up=0, one cycle after the tick.
- Continue ticks with ball_x=110,120,130, ball_y=50, REACT_FRAMES=2 -> WAIT at the x=110 tick with down=1 (home target 240). TRACK at the x=130 tick with paddle_up=1 (132>54).
- In TRACK, ball_y=134, paddle_y=100 -> both outputs 0 (dead zone). ball_y=137 -> paddle_down=1.
- Ball reverses (ball_x 130->120) during WAIT or TRACK -> HOME on that tick; the target returns to 240.
- Drop enable in TRACK -> next tick state=HOME, both 0. Assert rst_n=0 between ticks -> outputs 0 immediately; the next tick with increasing x does not leave HOME.
- paddle_y=1000, ball_y=0 -> paddle_up=1 with no wrap-around. Hold frame_tick=0 for 100 cycles -> outputs stable.

Source files
------------

// File: rtl/cpu_paddle_ctrl.sv
// CPU opponent for the right-hand Pong paddle: watches the ball once per frame
// and issues up/down requests after a reaction delay, with a dead zone.
module cpu_paddle_ctrl #(
  parameter int POS_W        = 10,
  parameter int SCREEN_H     = 480,
  parameter int PADDLE_H     = 64,
  parameter int DEAD_ZONE    = 4,
  parameter int REACT_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             frame_tick,
  input  logic [POS_W-1:0] ball_x,
  input  logic [POS_W-1:0] ball_y,
  input  logic [POS_W-1:0] paddle_y,
  output logic             paddle_up,
  output logic             paddle_down,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_HOME  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_TRACK = 2'd2
  } state_e;

  localparam logic [POS_W:0] HOME_Y = (POS_W+1)'(SCREEN_H / 2);
  localparam logic [POS_W:0] HALF_H = (POS_W+1)'(PADDLE_H / 2);
  localparam logic [POS_W:0] DZ     = (POS_W+1)'(DEAD_ZONE);
  localparam logic [3:0]     REACT  = 4'(REACT_FRAMES);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [POS_W-1:0] prev_x_q;
  logic             prev_valid_q;
  logic             up_q, up_d;
  logic             down_q, down_d;

  logic             approaching;
  logic [POS_W:0]   centre;
  logic [POS_W:0]   target;

  assign approaching = prev_valid_q && (ball_x > prev_x_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = ST_HOME;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        ST_HOME: begin
          if (approaching) begin
            state_d = (REACT == 4'd0) ? ST_TRACK : ST_WAIT;
            cnt_d   = REACT;
          end
        end
        ST_WAIT: begin
          if (!approaching)        state_d = ST_HOME;
          else if (cnt_q <= 4'd1)  state_d = ST_TRACK;
          else                     cnt_d   = cnt_q - 4'd1;
        end
        ST_TRACK: begin
          if (!approaching) state_d = ST_HOME;
        end
        default: state_d = ST_HOME;
      endcase
    end
  end

  // Extra bit keeps centre and target+DZ from wrapping near the bottom edge.
  always_comb begin
    centre = {1'b0, paddle_y} + HALF_H;
    target = (state_d == ST_TRACK) ? {1'b0, ball_y} : HOME_Y;
    down_d = enable && ((centre + DZ) < target);
    up_d   = enable && (centre > (target + DZ));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HOME;
      cnt_q        <= 4'd0;
      prev_x_q     <= '0;
      prev_valid_q <= 1'b0;
      up_q         <= 1'b0;
      down_q       <= 1'b0;
    end else if (frame_tick) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prev_x_q     <= ball_x;
      prev_valid_q <= 1'b1;
      up_q         <= up_d;
      down_q       <= down_d;
    end
  end

  assign paddle_up   = up_q;
  assign paddle_down = down_q;
  assign state       = state_q;

endmodule

// File: tb/tb_cpu_paddle_ctrl.sv
// Directed bench for cpu_paddle_ctrl: expected state/outputs are queued per tick
// and compared one clock later.
module tb_cpu_paddle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       frame_tick;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [9:0] paddle_y;
  logic       paddle_up;
  logic       paddle_down;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  logic [3:0] sb_q[$];
  logic [3:0] last_exp;

  cpu_paddle_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .frame_tick (frame_tick),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .paddle_y   (paddle_y),
    .paddle_up  (paddle_up),
    .paddle_down(paddle_down),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed st=%0d up=%0d dn=%0d expected st=%0d up=%0d dn=%0d",
             tag, obs[3:2], obs[1], obs[0], exp[3:2], exp[1], exp[0]);
    end
  endtask

  // Drives one tick at a negedge; result is checked at the following negedge.
  task automatic tick(input string tag, input int x, input int y, input int py,
                      input bit en, input logic [1:0] st);
    int   tgt, c;
    logic u, d;
    logic [3:0] exp;
    ball_x     = 10'(x);
    ball_y     = 10'(y);
    paddle_y   = 10'(py);
    enable     = en;
    frame_tick = 1'b1;
    tgt = (st == 2'd2) ? y : 240;
    c   = py + 32;
    d   = en && (c + 4 < tgt);
    u   = en && (c > tgt + 4);
    sb_q.push_back({st, u, d});
    @(posedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
    exp = sb_q.pop_front();
    last_exp = exp;
    check(tag, {state, paddle_up, paddle_down}, exp);
    $display("tick %-6s x=%0d y=%0d py=%0d en=%0d -> st=%0d up=%0d dn=%0d",
             tag, x, y, py, en, state, paddle_up, paddle_down);
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b1;
    frame_tick = 1'b0;
    ball_x     = '0;
    ball_y     = '0;
    paddle_y   = '0;
    repeat (3) @(negedge clk);
    check("reset", {state, paddle_up, paddle_down}, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);

    tick("t1",  100,  50, 100, 1'b1, 2'd0);
    tick("t2",  110,  50, 100, 1'b1, 2'd1);
    tick("t3",  120,  50, 100, 1'b1, 2'd1);
    tick("t4",  130,  50, 100, 1'b1, 2'd2);
    tick("dz134", 140, 134, 100, 1'b1, 2'd2);
    tick("dn137", 150, 137, 100, 1'b1, 2'd2);
    tick("dz136", 160, 136, 100, 1'b1, 2'd2);
    tick("dz128", 170, 128, 100, 1'b1, 2'd2);
    tick("up127", 180, 127, 100, 1'b1, 2'd2);
    tick("revT",  170,  50, 100, 1'b1, 2'd0);
    tick("w1",    180,  50, 100, 1'b1, 2'd1);
    tick("revW",  170,  50, 100, 1'b1, 2'd0);
    tick("w2",    180,  50, 100, 1'b1, 2'd1);
    tick("w3",    190,  50, 100, 1'b1, 2'd1);
    tick("tr2",   200,  50, 100, 1'b1, 2'd2);
    tick("dis",   210,  50, 100, 1'b0, 2'd0);
    tick("reen",  220,  50, 100, 1'b1, 2'd1);

    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst", {state, paddle_up, paddle_down}, 4'b0000);
    $display("reset pulse -> st=%0d up=%0d dn=%0d", state, paddle_up, paddle_down);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    tick("post",  230,  10, 100,  1'b1, 2'd0);
    tick("homeW", 240,  10, 1000, 1'b1, 2'd1);
    tick("w4",    250,  10, 1000, 1'b1, 2'd1);
    tick("nowrap",260,  10, 1000, 1'b1, 2'd2);

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("hold", {state, paddle_up, paddle_down}, last_exp);
    end
    $display("idle 100 cycles -> st=%0d up=%0d dn=%0d", state, paddle_up, paddle_down);

    checks++;
    assert (sb_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard observed %0d leftover expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
